wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries; SHALL be a power of two, 2 to 16.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; low clears all state immediately, regardless of clk.
REQ-004 memValid  in  1  load-result producer has a write to offer.
REQ-005 memReady  out  1  queue accepts the load-result offer this cycle.
REQ-006 memAddr  in  5  destination register of the load result.
REQ-007 memData  in  32  load result value.
REQ-008 aluValid  in  1  ALU producer has a write to offer.
REQ-009 aluReady  out  1  queue accepts the ALU offer this cycle.
REQ-010 aluAddr  in  5  destination register of the ALU result.
REQ-011 aluData  in  32  ALU result value.
REQ-012 stall  in  1  high blocks draining to the register file.
REQ-013 regWrite  out  1  register-file write enable.
REQ-014 writeAddr  out  5  register-file write address.
REQ-015 writeData  out  32  register-file write data.
REQ-016 lookupAddr1  in  5  decode-stage read address 1.
REQ-017 fwdHit1  out  1  a pending write to lookupAddr1 exists.
REQ-018 fwdData1  out  32  data of the youngest pending write to lookupAddr1.
REQ-019 lookupAddr2, fwdHit2, fwdData2: same as REQ-016 to REQ-018 for read port 2.
REQ-020 count  out  clog2(DEPTH)+1  number of occupied entries.
REQ-021 empty  out  1  count == 0.

Function
REQ-022 Storage SHALL be a circular FIFO of DEPTH {addr, data} entries, with head and tail pointers that wrap modulo DEPTH.
REQ-023 A handshake SHALL complete on a rising edge when valid and ready are both high; ready SHALL depend only on registered state and on memValid.
REQ-024 memReady SHALL be (count < DEPTH).
REQ-025 aluReady SHALL be (count < DEPTH) && !memValid; the load producer has fixed priority.
REQ-026 At most one entry SHALL be enqueued per cycle.
REQ-027 An accepted offer with addr == 0 SHALL complete its handshake but SHALL NOT be enqueued, and count SHALL NOT change.
REQ-028 regWrite SHALL be !empty && !stall; writeAddr and writeData SHALL show the head entry combinationally.
REQ-029 The head entry SHALL be popped on every rising edge where regWrite is high.
REQ-030 Latency: an entry accepted at edge N SHALL reach regWrite no earlier than the cycle after edge N; entries SHALL drain in acceptance order.
REQ-031 A push and a pop on the same edge SHALL leave count unchanged; when full, a same-edge pop SHALL NOT make ready high in that cycle.
REQ-032 fwdHitK SHALL be high iff lookupAddrK != 0 and an occupied entry has addr == lookupAddrK.
REQ-033 fwdDataK SHALL be the data of the youngest matching occupied entry; when fwdHitK is low it SHALL be 0.
REQ-034 Forwarding SHALL NOT consider offers not yet accepted; the head entry SHALL still match during the cycle it drains.
REQ-035 Free-running operation SHALL wrap pointers indefinitely with no loss or reordering of entries.

Reset
REQ-036 While reset is low: count = 0, empty = 1, regWrite = 0, writeAddr = 0, writeData = 0, fwdHit1/2 = 0, fwdData1/2 = 0, pointers = 0, all entry storage = 0.
REQ-037 Ready outputs during and after reset SHALL follow REQ-024 and REQ-025; with the queue empty this gives memReady = 1 and aluReady = !memValid.
REQ-038 Reset asserted mid-operation SHALL discard all pending entries, and no write of a discarded entry SHALL ever appear on regWrite.

Verification
REQ-039 Single write: after reset, alu {5, 0xDEADBEEF} accepted at edge 1, stall = 0 -> cycle after edge 1: regWrite = 1, writeAddr = 5, writeData = 0xDEADBEEF; count = 0 after edge 2.
REQ-040 Arbitration: memValid {3, 0x11} and aluValid {4, 0x22} high together -> memReady = 1, aluReady = 0; mem entry enqueued first, alu entry the next cycle; drain order 3 then 4.
REQ-041 Full and stall: stall = 1, alu writes to regs 1..4 on consecutive edges (DEPTH = 4) -> count = 4, both readies low, regWrite = 0; release stall -> four writes in order 1, 2, 3, 4, then empty = 1.
REQ-042 Forwarding: stall = 1, enqueue {7, 0xA} then {7, 0xB}, lookupAddr1 = 7, lookupAddr2 = 0 -> fwdHit1 = 1, fwdData1 = 0xB, fwdHit2 = 0, fwdData2 = 0.
REQ-043 Zero register: alu {0, 0x55} accepted -> aluReady was high, count stays 0, regWrite never high.
REQ-044 Reset mid-operation: three entries pending with stall = 1; pulse reset low between edges -> count = 0 immediately; after stall releases, no regWrite pulse occurs.

Source files
------------

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - register-file write-back queue with two-producer arbitration and forwarding
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memValid,
  output logic                     memReady,
  input  logic [4:0]               memAddr,
  input  logic [31:0]              memData,
  input  logic                     aluValid,
  output logic                     aluReady,
  input  logic [4:0]               aluAddr,
  input  logic [31:0]              aluData,
  input  logic                     stall,
  output logic                     regWrite,
  output logic [4:0]               writeAddr,
  output logic [31:0]              writeData,
  input  logic [4:0]               lookupAddr1,
  output logic                     fwdHit1,
  output logic [31:0]              fwdData1,
  input  logic [4:0]               lookupAddr2,
  output logic                     fwdHit2,
  output logic [31:0]              fwdData2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]  addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count_q;

  logic        not_full;
  logic        mem_fire;
  logic        alu_fire;
  logic [4:0]  push_addr;
  logic [31:0] push_data;
  logic        push;
  logic        pop;
  logic [AW-1:0] idx;

  // Readiness only looks at registered occupancy, so a same-edge pop never frees a slot early.
  assign not_full = count_q < (AW+1)'(DEPTH);
  assign memReady = not_full;
  assign aluReady = not_full && !memValid;

  assign mem_fire  = memValid && memReady;
  assign alu_fire  = aluValid && aluReady;
  assign push_addr = mem_fire ? memAddr : aluAddr;
  assign push_data = mem_fire ? memData : aluData;
  // Writes to r0 complete the handshake but are dropped here.
  assign push      = (mem_fire || alu_fire) && (push_addr != 5'd0);

  assign empty     = (count_q == '0);
  assign pop       = !empty && !stall;
  assign regWrite  = pop;
  assign writeAddr = addr_q[head];
  assign writeData = data_q[head];
  assign count     = count_q;

  // Entry storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= push_addr;
        data_q[tail] <= push_data;
        tail         <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Forwarding: scan occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwdHit1  = 1'b0;
    fwdData1 = '0;
    fwdHit2  = 1'b0;
    fwdData2 = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if (lookupAddr1 != 5'd0 && addr_q[idx] == lookupAddr1) begin
          fwdHit1  = 1'b1;
          fwdData1 = data_q[idx];
        end
        if (lookupAddr2 != 5'd0 && addr_q[idx] == lookupAddr2) begin
          fwdHit2  = 1'b1;
          fwdData2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue with a pending-write scoreboard
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        stall = 1'b0;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  lookup1 = '0;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic [4:0]  lookup2 = '0;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int passed = 0;
  logic [36:0] sb[$];

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(rst_n),
    .memValid(mem_valid), .memReady(mem_ready), .memAddr(mem_addr), .memData(mem_data),
    .aluValid(alu_valid), .aluReady(alu_ready), .aluAddr(alu_addr), .aluData(alu_data),
    .stall(stall), .regWrite(reg_write), .writeAddr(write_addr), .writeData(write_data),
    .lookupAddr1(lookup1), .fwdHit1(fwd_hit1), .fwdData1(fwd_data1),
    .lookupAddr2(lookup2), .fwdHit2(fwd_hit2), .fwdData2(fwd_data2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    lookup1 = 5'd5; lookup2 = 5'd5;
    @(negedge clk);
    checks++;
    if ({count, empty, reg_write, write_addr, write_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, mem_ready, alu_ready}
        !== {3'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1})
      $display("FAIL reset_state: cnt=%0d empty=%b rw=%b wa=%0d wd=%h hit=%b%b rdy=%b%b", count, empty, reg_write,
               write_addr, write_data, fwd_hit1, fwd_hit2, mem_ready, alu_ready);
    else passed++;
    mem_valid = 1'b1;
    #1;
    checks++;
    if ({mem_ready, alu_ready} !== 2'b10)
      $display("FAIL reset_ready_memvalid: got %b expected 10", {mem_ready, alu_ready});
    else passed++;
    next_drive();
    rst_n = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0; lookup1 = '0; lookup2 = '0;
    @(negedge clk);
    checks++;
    if ({count, empty, reg_write} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL post_reset_idle: got %b expected 00010", {count, empty, reg_write});
    else passed++;
    next_drive();
  endtask

  task automatic test_single();
    logic [36:0] e;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({alu_ready, reg_write} !== 2'b10)
      $display("FAIL single_accept: got %b expected 10", {alu_ready, reg_write});
    else passed++;
    sb.push_back({5'd5, 32'hDEADBEEF});
    next_drive();
    alu_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({reg_write, write_addr, write_data} !== {1'b1, e})
      $display("FAIL single_write: got rw=%b %0d/%h expected 1 %0d/%h", reg_write, write_addr, write_data, e[36:32], e[31:0]);
    else passed++;
    next_drive();
    @(negedge clk);
    checks++;
    if ({count, reg_write} !== 4'd0)
      $display("FAIL single_done: got cnt=%0d rw=%b expected 0 0", count, reg_write);
    else passed++;
    next_drive();
  endtask

  task automatic test_arbitration();
    logic [36:0] e;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
    @(negedge clk);
    checks++;
    if ({mem_ready, alu_ready} !== 2'b10)
      $display("FAIL arb_ready: got %b expected 10", {mem_ready, alu_ready});
    else passed++;
    sb.push_back({5'd3, 32'h11});
    next_drive();
    mem_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({alu_ready, reg_write, write_addr, write_data} !== {2'b11, e})
      $display("FAIL arb_first: got rdy=%b rw=%b %0d/%h expected 1 1 %0d/%h", alu_ready, reg_write, write_addr,
               write_data, e[36:32], e[31:0]);
    else passed++;
    sb.push_back({5'd4, 32'h22});
    next_drive();
    alu_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (reg_write) begin
        e = sb.pop_front();
        checks++;
        if ({write_addr, write_data} !== e)
          $display("FAIL arb_drain: got %0d/%h expected %0d/%h", write_addr, write_data, e[36:32], e[31:0]);
        else passed++;
      end
      next_drive();
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || empty !== 1'b1)
      $display("FAIL arb_drain_done: got empty=%b left=%0d expected 1 0", empty, sb.size());
    else passed++;
    next_drive();
  endtask

  task automatic test_full_stall();
    logic [36:0] e;
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'h100 + 32'(i);
      @(negedge clk);
      checks++;
      if (alu_ready !== 1'b1)
        $display("FAIL full_fill_ready: got %b expected 1 at entry %0d", alu_ready, i);
      else passed++;
      sb.push_back({5'(i), 32'h100 + 32'(i)});
      next_drive();
    end
    alu_addr = 5'd9; mem_valid = 1'b1; mem_addr = 5'd9;
    @(negedge clk);
    checks++;
    if ({count, mem_ready, alu_ready, reg_write} !== {3'd4, 3'b000})
      $display("FAIL full_state: got cnt=%0d rdy=%b%b rw=%b expected 4 00 0", count, mem_ready, alu_ready, reg_write);
    else passed++;
    next_drive();
    stall = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({mem_ready, reg_write, write_addr, write_data} !== {2'b01, e})
      $display("FAIL full_pop_ready: got rdy=%b rw=%b %0d expected 0 1 %0d", mem_ready, reg_write, write_addr, e[36:32]);
    else passed++;
    next_drive();
    mem_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (reg_write) begin
        e = sb.pop_front();
        checks++;
        if ({write_addr, write_data} !== e)
          $display("FAIL full_drain: got %0d/%h expected %0d/%h", write_addr, write_data, e[36:32], e[31:0]);
        else passed++;
      end
      next_drive();
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || {empty, count} !== 4'b1000)
      $display("FAIL full_drain_done: got empty=%b cnt=%0d left=%0d expected 1 0 0", empty, count, sb.size());
    else passed++;
    next_drive();
  endtask

  task automatic test_forwarding();
    logic [36:0] e;
    stall = 1'b1; lookup1 = 5'd7; lookup2 = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA;
    @(negedge clk);
    checks++;
    if ({fwd_hit1, fwd_data1} !== 33'd0)
      $display("FAIL fwd_unaccepted: got %b/%h expected 0/0", fwd_hit1, fwd_data1);
    else passed++;
    sb.push_back({5'd7, 32'hA});
    next_drive();
    alu_data = 32'hB;
    @(negedge clk);
    checks++;
    if ({fwd_hit1, fwd_data1} !== {1'b1, 32'hA})
      $display("FAIL fwd_one: got %b/%h expected 1/a", fwd_hit1, fwd_data1);
    else passed++;
    sb.push_back({5'd7, 32'hB});
    next_drive();
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 32'hB, 1'b0, 32'h0})
      $display("FAIL fwd_youngest: got %b/%h %b/%h expected 1/b 0/0", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    else passed++;
    lookup2 = 5'd3;
    #1;
    checks++;
    if ({fwd_hit2, fwd_data2} !== 33'd0)
      $display("FAIL fwd_nomatch: got %b/%h expected 0/0", fwd_hit2, fwd_data2);
    else passed++;
    next_drive();
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({reg_write, write_addr, write_data, fwd_hit1, fwd_data1} !== {1'b1, e, 1'b1, 32'hB})
        $display("FAIL fwd_drain: got rw=%b %0d/%h hit=%b/%h expected 1 %0d/%h 1/b", reg_write, write_addr, write_data,
                 fwd_hit1, fwd_data1, e[36:32], e[31:0]);
      else passed++;
      next_drive();
    end
    @(negedge clk);
    checks++;
    if ({fwd_hit1, empty} !== 2'b01)
      $display("FAIL fwd_after_drain: got hit=%b empty=%b expected 0 1", fwd_hit1, empty);
    else passed++;
    lookup1 = '0; lookup2 = '0;
    next_drive();
  endtask

  task automatic test_zero_reg();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1)
      $display("FAIL zero_ready: got %b expected 1", alu_ready);
    else passed++;
    next_drive();
    alu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({count, reg_write} !== 4'd0)
        $display("FAIL zero_no_write: got cnt=%0d rw=%b expected 0 0", count, reg_write);
      else passed++;
      next_drive();
    end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1; lookup1 = 5'd10;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(9 + i); alu_data = 32'hC0 + 32'(i);
      next_drive();
    end
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, fwd_hit1} !== {3'd3, 1'b1})
      $display("FAIL rstmid_pending: got cnt=%0d hit=%b expected 3 1", count, fwd_hit1);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, reg_write, fwd_hit1, fwd_data1} !== {3'd0, 1'b1, 1'b0, 1'b0, 32'd0})
      $display("FAIL rstmid_immediate: got cnt=%0d empty=%b rw=%b hit=%b expected 0 1 0 0", count, empty, reg_write, fwd_hit1);
    else passed++;
    rst_n = 1'b1;
    next_drive();
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({reg_write, count} !== 4'd0)
        $display("FAIL rstmid_no_write: got rw=%b cnt=%0d expected 0 0", reg_write, count);
      else passed++;
      next_drive();
    end
    lookup1 = '0;
  endtask

  task automatic test_random();
    int n;
    logic h1, h2;
    logic [31:0] d1, d2;
    logic [36:0] e;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      mem_valid = ($urandom_range(0, 2) == 0); mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
      alu_valid = ($urandom_range(0, 1) == 0); alu_addr = 5'($urandom_range(0, 7)); alu_data = $urandom;
      lookup1 = 5'($urandom_range(0, 7)); lookup2 = 5'($urandom_range(0, 7));
      @(negedge clk);
      n = sb.size();
      checks++;
      if ({count, mem_ready, alu_ready, reg_write} !== {3'(n), n < 4, n < 4 && !mem_valid, n != 0 && !stall})
        $display("FAIL rand_ctrl: cycle %0d got cnt=%0d rdy=%b%b rw=%b expected cnt=%0d", c, count, mem_ready,
                 alu_ready, reg_write, n);
      else passed++;
      h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
      for (int j = 0; j < n; j++) begin
        if (lookup1 != 0 && sb[j][36:32] == lookup1) begin h1 = 1'b1; d1 = sb[j][31:0]; end
        if (lookup2 != 0 && sb[j][36:32] == lookup2) begin h2 = 1'b1; d2 = sb[j][31:0]; end
      end
      checks++;
      if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {h1, d1, h2, d2})
        $display("FAIL rand_fwd: cycle %0d got %b/%h %b/%h expected %b/%h %b/%h", c, fwd_hit1, fwd_data1, fwd_hit2,
                 fwd_data2, h1, d1, h2, d2);
      else passed++;
      if (n != 0 && !stall) begin
        e = sb.pop_front();
        checks++;
        if ({write_addr, write_data} !== e)
          $display("FAIL rand_write: cycle %0d got %0d/%h expected %0d/%h", c, write_addr, write_data, e[36:32], e[31:0]);
        else passed++;
      end
      if (n < 4 && mem_valid) begin
        if (mem_addr != 0) sb.push_back({mem_addr, mem_data});
      end else if (n < 4 && alu_valid) begin
        if (alu_addr != 0) sb.push_back({alu_addr, alu_data});
      end
      next_drive();
    end
    mem_valid = 1'b0; alu_valid = 1'b0; stall = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (reg_write) begin
        e = sb.pop_front();
        checks++;
        if ({write_addr, write_data} !== e)
          $display("FAIL rand_drain: got %0d/%h expected %0d/%h", write_addr, write_data, e[36:32], e[31:0]);
        else passed++;
      end
      next_drive();
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || empty !== 1'b1)
      $display("FAIL rand_drain_done: got empty=%b left=%0d expected 1 0", empty, sb.size());
    else passed++;
    lookup1 = '0; lookup2 = '0;
    next_drive();
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_full_stall();
    test_forwarding();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
